// File: rtl/inst_encoder_loader_pkg.sv
// Shared definitions for the RV32I instruction encoder/loader.
// Holds the field-set format codes, the base opcodes and the immediate range
// limits that the encoder uses for its legality checks.
package inst_encoder_loader_pkg;

    // Format selector values carried on the fmt input (6 and 7 are illegal)
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // Inclusive signed limits of each immediate field
    localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
    localparam logic signed [31:0] IMM12_MAX = 32'sd2047;
    localparam logic signed [31:0] SHAMT_MIN = 32'sd0;
    localparam logic signed [31:0] SHAMT_MAX = 32'sd31;
    localparam logic signed [31:0] BIMM_MIN  = -32'sd4096;
    localparam logic signed [31:0] BIMM_MAX  = 32'sd4094;
    localparam logic signed [31:0] JIMM_MIN  = -32'sd1048576;
    localparam logic signed [31:0] JIMM_MAX  = 32'sd1048574;

    // True when the immediate, read as two's complement, lies in [lo, hi]
    function automatic logic immInRange(input logic [31:0] imm,
                                        input logic signed [31:0] lo,
                                        input logic signed [31:0] hi);
        return ($signed(imm) >= lo) && ($signed(imm) <= hi);
    endfunction

endpackage

// File: rtl/inst_encoder_loader_inst_fifo.sv
// Synchronous FIFO with occupancy count, used to buffer tagged instruction
// words. rdata_o shows the head entry; when empty it holds the last entry
// popped (zero after reset) so the consumer never sees stale slots.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clr_i           synchronous flush (wins over push and pop)
//   push_i, wdata_i write request and data (ignored when full)
//   pop_i           remove head (ignored when empty)
//   rdata_o         head data
//   full_o, empty_o status flags from current occupancy
//   count_o         number of stored entries
module inst_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = empty_o ? last_q : mem[rdPtr_q];

    // Full is judged on current occupancy, so a same-cycle pop never frees
    // room for a push into a full FIFO.
    assign doPush = push_i && !full_o && !clr_i;
    assign doPop  = pop_i && !empty_o && !clr_i;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        last_d  = last_q;
        if (clr_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (doPush) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
                last_d  = mem[rdPtr_q];
            end
            case ({doPush, doPop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            last_q  <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

    // Storage needs no reset: slots are only visible while counted as valid.
    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem[wrPtr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/inst_encoder_loader.sv
// Packs RV32I instruction fields plus a full 32-bit immediate into an
// instruction word, rejects immediates that do not fit the chosen format,
// tags each legal word with a sequential byte address and streams the
// {word, address} pairs out of a small FIFO over valid/ready.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   clr                  synchronous flush of FIFO, address counter, err_flag
//   in_valid, in_ready   field-set handshake
//   fmt, opcode, rd, rs1, rs2, funct3, funct7, imm   instruction fields
//   out_valid, out_ready output handshake
//   out_inst, out_addr   head word and its byte address
//   count                FIFO occupancy
//   err, err_flag        one-cycle reject pulse, sticky reject flag
module inst_encoder_loader
    import inst_encoder_loader_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             fmt,
    input  logic [6:0]             opcode,
    input  logic [4:0]             rd,
    input  logic [4:0]             rs1,
    input  logic [4:0]             rs2,
    input  logic [2:0]             funct3,
    input  logic [6:0]             funct7,
    input  logic [31:0]            imm,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_inst,
    output logic [31:0]            out_addr,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err,
    output logic                   err_flag
);

    fmt_e        fmtSel;
    logic [31:0] encWord;
    logic        setBad;
    logic        isShiftI;
    logic        accept;
    logic        fifoFull;
    logic        fifoEmpty;
    logic [63:0] fifoHead;
    logic [31:0] addr_q, addr_d;
    logic        err_q, err_d;
    logic        errFlag_q, errFlag_d;

    assign fmtSel   = fmt_e'(fmt);
    assign isShiftI = (opcode == OP_IMM) && ((funct3 == 3'b001) || (funct3 == 3'b101));

    // Encode the field set and decide whether its immediate is legal.
    always_comb begin
        encWord = '0;
        setBad  = 1'b0;
        case (fmtSel)
            FMT_R: begin
                encWord = {funct7, rs2, rs1, funct3, rd, opcode};
            end
            FMT_I: begin
                if (isShiftI) begin
                    encWord = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                    setBad  = !immInRange(imm, SHAMT_MIN, SHAMT_MAX);
                end else begin
                    encWord = {imm[11:0], rs1, funct3, rd, opcode};
                    setBad  = !immInRange(imm, IMM12_MIN, IMM12_MAX);
                end
            end
            FMT_S: begin
                encWord = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                setBad  = !immInRange(imm, IMM12_MIN, IMM12_MAX);
            end
            FMT_B: begin
                encWord = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                setBad  = !immInRange(imm, BIMM_MIN, BIMM_MAX) || imm[0];
            end
            FMT_U: begin
                encWord = {imm[31:12], rd, opcode};
                setBad  = (imm[11:0] != 12'd0);
            end
            FMT_J: begin
                encWord = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                setBad  = !immInRange(imm, JIMM_MIN, JIMM_MAX) || imm[0];
            end
            default: begin
                setBad = 1'b1;
            end
        endcase
    end

    // in_ready is held low during reset so nothing is accepted mid-reset.
    assign in_ready = rst_n && !fifoFull && !clr;
    assign accept   = in_valid && in_ready;

    // Rejected sets still complete the handshake but leave address untouched.
    always_comb begin
        addr_d    = addr_q;
        err_d     = accept && setBad;
        errFlag_d = errFlag_q;
        if (clr) begin
            addr_d    = BASE_ADDR;
            errFlag_d = 1'b0;
        end else if (accept) begin
            if (setBad) begin
                errFlag_d = 1'b1;
            end else begin
                addr_d = addr_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= BASE_ADDR;
            err_q     <= 1'b0;
            errFlag_q <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            err_q     <= err_d;
            errFlag_q <= errFlag_d;
        end
    end

    inst_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clr_i   (clr),
        .push_i  (accept && !setBad),
        .wdata_i ({encWord, addr_q}),
        .pop_i   (out_ready),
        .rdata_o (fifoHead),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (count)
    );

    assign out_valid = !fifoEmpty;
    assign out_inst  = fifoHead[63:32];
    assign out_addr  = fifoHead[31:0];
    assign err       = err_q;
    assign err_flag  = errFlag_q;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Self-checking bench for inst_encoder_loader. Expected {word, address}
// pairs are queued when a legal set is accepted and compared when the DUT
// hands the head over on out_valid && out_ready.
module tb_inst_encoder_loader;
    import inst_encoder_loader_pkg::*;

    localparam int DEPTH = 4;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp;
    } set_t;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_addr;
    logic [$clog2(DEPTH):0] count;
    logic        err;
    logic        err_flag;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb [$];
    logic [31:0] expAddr;

    inst_encoder_loader #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fmt       (fmt),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .funct7    (funct7),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_addr  (out_addr),
        .count     (count),
        .err       (err),
        .err_flag  (err_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after posedge; the monitor samples at negedge.
    always @(negedge clk) begin
        logic [63:0] expPair;
        if (!rst_n || clr) begin
            sb.delete();
        end else if (out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_output: got inst=%08h addr=%08h, expected no output", out_inst, out_addr);
            end else begin
                expPair = sb.pop_front();
                if ({out_inst, out_addr} !== expPair) begin
                    errors++;
                    $display("[TB] FAIL stream_word: got inst=%08h addr=%08h, expected inst=%08h addr=%08h",
                             out_inst, out_addr, expPair[63:32], expPair[31:0]);
                end
            end
        end
    end

    function automatic set_t mk(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                                input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] im, input logic [31:0] ex);
        set_t s;
        s.fmt = f; s.op = op; s.rd = d; s.rs1 = s1; s.rs2 = s2;
        s.f3 = f3; s.f7 = f7; s.imm = im; s.exp = ex;
        return s;
    endfunction

    // Present a set and hold it until it is accepted (bounded wait).
    task automatic drive_set(input set_t s, input bit legal);
        bit done;
        done = 1'b0;
        fmt = s.fmt; opcode = s.op; rd = s.rd; rs1 = s.rs1; rs2 = s.rs2;
        funct3 = s.f3; funct7 = s.f7; imm = s.imm; in_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                if (legal) begin
                    sb.push_back({s.exp, expAddr});
                    expAddr = expAddr + 32'd4;
                end
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL accept_timeout: in_ready stayed %b, expected 1 within 100 cycles", in_ready);
        end
    endtask

    task automatic wait_drain();
        out_ready = 1'b1;
        for (int i = 0; i < 100 && count != 0; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (count !== '0 || sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: count=%0d pending=%0d, expected 0 and 0", count, sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        fmt = 3'd1; opcode = OP_IMM; rd = 5'd1; rs1 = 5'd0; rs2 = 5'd0;
        funct3 = 3'd0; funct7 = 7'd0; imm = 32'd5;
        expAddr = BASE_ADDR;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (in_ready !== 1'b0 || count !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: in_ready=%b count=%0d out_valid=%b, expected 0 0 0", in_ready, count, out_valid);
        end
        checks++;
        if (out_inst !== 32'd0 || out_addr !== 32'd0 || err !== 1'b0 || err_flag !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_data: inst=%08h addr=%08h err=%b flag=%b, expected all 0", out_inst, out_addr, err, err_flag);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_encode();
        set_t s [$];
        // First word checked directly at the head with the consumer stalled
        out_ready = 1'b0;
        drive_set(mk(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, 32'h00500093), 1'b1);
        checks++;
        if (out_valid !== 1'b1 || count !== 3'd1 || out_inst !== 32'h00500093 || out_addr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL addi_latency: valid=%b count=%0d inst=%08h addr=%08h, expected 1 1 00500093 00000000",
                     out_valid, count, out_inst, out_addr);
        end
        out_ready = 1'b1;
        s.push_back(mk(FMT_S, OP_STORE,  5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8,          32'h0020A423));
        s.push_back(mk(FMT_B, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, -32'sd4,        32'hFE208EE3));
        s.push_back(mk(FMT_U, OP_LUI,    5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345000,   32'h123452B7));
        s.push_back(mk(FMT_U, OP_AUIPC,  5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h00001000,   32'h00001097));
        s.push_back(mk(FMT_J, OP_JAL,    5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd8,          32'h008000EF));
        s.push_back(mk(FMT_J, OP_JAL,    5'd0, 5'd0, 5'd0, 3'b000, 7'd0, -32'sd1048576,  32'h8000006F));
        s.push_back(mk(FMT_R, OP_REG,    5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0,          32'h002081B3));
        s.push_back(mk(FMT_I, OP_IMM,    5'd1, 5'd1, 5'd0, 3'b001, 7'd0, 32'd3,          32'h00309093));
        s.push_back(mk(FMT_I, OP_IMM,    5'd1, 5'd1, 5'd0, 3'b101, 7'b0100000, 32'd3,    32'h4030D093));
        s.push_back(mk(FMT_I, OP_JALR,   5'd0, 5'd1, 5'd0, 3'b000, 7'd0, 32'd0,          32'h00008067));
        s.push_back(mk(FMT_I, OP_LOAD,   5'd2, 5'd1, 5'd0, 3'b010, 7'd0, 32'd4,          32'h0040A103));
        s.push_back(mk(FMT_I, OP_IMM,    5'd1, 5'd0, 5'd0, 3'b000, 7'd0, -32'sd2048,     32'h80000093));
        s.push_back(mk(FMT_I, OP_IMM,    5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2047,       32'h7FF00093));
        s.push_back(mk(FMT_B, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd4094,       32'h7E208FE3));
        foreach (s[i]) drive_set(s[i], 1'b1);
        wait_drain();
    endtask

    task automatic test_reject();
        set_t s [$];
        logic [31:0] addrBefore;
        s.push_back(mk(FMT_U, OP_LUI,  5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345001, 32'h0));
        s.push_back(mk(FMT_J, OP_JAL,  5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd3,        32'h0));
        s.push_back(mk(FMT_I, OP_IMM,  5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048,     32'h0));
        s.push_back(mk(FMT_I, OP_IMM,  5'd1, 5'd1, 5'd0, 3'b001, 7'd0, 32'd32,       32'h0));
        s.push_back(mk(3'd7,  OP_IMM,  5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd0,        32'h0));
        s.push_back(mk(FMT_B, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd4096,   32'h0));
        addrBefore = expAddr;
        out_ready = 1'b1;
        foreach (s[i]) begin
            drive_set(s[i], 1'b0);
            checks++;
            if (err !== 1'b1 || err_flag !== 1'b1 || count !== '0 || out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reject_%0d: err=%b flag=%b count=%0d valid=%b, expected 1 1 0 0",
                         i, err, err_flag, count, out_valid);
            end
            @(posedge clk); #1;
            checks++;
            if (err !== 1'b0 || err_flag !== 1'b1) begin
                errors++;
                $display("[TB] FAIL reject_pulse_%0d: err=%b flag=%b, expected 0 1", i, err, err_flag);
            end
        end
        // A following legal word must carry the address the rejects did not consume
        out_ready = 1'b0;
        drive_set(mk(FMT_U, OP_LUI, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345000, 32'h123452B7), 1'b1);
        checks++;
        if (out_addr !== addrBefore) begin
            errors++;
            $display("[TB] FAIL reject_addr: got %08h, expected %08h", out_addr, addrBefore);
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        set_t s;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s = mk(FMT_I, OP_IMM, 5'(i + 1), 5'd0, 5'd0, 3'b000, 7'd0, 32'(i),
                   {12'(i), 5'd0, 3'b000, 5'(i + 1), OP_IMM});
            if (i < 4) begin
                drive_set(s, 1'b1);
            end else begin
                checks++;
                if (count !== 3'd4 || in_ready !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL full: count=%0d in_ready=%b, expected 4 0", count, in_ready);
                end
                fmt = s.fmt; opcode = s.op; rd = s.rd; rs1 = s.rs1; rs2 = s.rs2;
                funct3 = s.f3; funct7 = s.f7; imm = s.imm; in_valid = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                checks++;
                if (count !== 3'd4 || in_ready !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL full_hold: count=%0d in_ready=%b, expected 4 0", count, in_ready);
                end
                out_ready = 1'b1;
                drive_set(s, 1'b1);
            end
        end
        wait_drain();
        // Push and pop in the same cycle with two entries stored
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_set(mk(FMT_R, OP_REG, 5'(i + 3), 5'd1, 5'd2, 3'b000, 7'd0, 32'd0,
                         {7'd0, 5'd2, 5'd1, 3'b000, 5'(i + 3), OP_REG}), 1'b1);
        end
        out_ready = 1'b1;
        drive_set(mk(FMT_S, OP_STORE, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 32'h0020A423), 1'b1);
        checks++;
        if (count !== 3'd2) begin
            errors++;
            $display("[TB] FAIL push_pop_count: got %0d, expected 2", count);
        end
        wait_drain();
    endtask

    task automatic test_clear();
        set_t s;
        s = mk(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, 32'h00500093);
        // Leave a sticky error behind so the flush can be seen clearing it
        drive_set(mk(3'd6, OP_IMM, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd0, 32'h0), 1'b0);
        out_ready = 1'b0;
        drive_set(s, 1'b1);
        drive_set(s, 1'b1);
        checks++;
        if (err_flag !== 1'b1 || count !== 3'd2) begin
            errors++;
            $display("[TB] FAIL pre_clear: flag=%b count=%0d, expected 1 2", err_flag, count);
        end
        clr = 1'b1;
        in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clr_in_ready: got %b, expected 0", in_ready);
        end
        @(posedge clk); #1;
        clr = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        expAddr = BASE_ADDR;
        checks++;
        if (count !== '0 || out_valid !== 1'b0 || err_flag !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear_state: count=%0d valid=%b flag=%b, expected 0 0 0", count, out_valid, err_flag);
        end
        s = mk(FMT_J, OP_JAL, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd8, 32'h008000EF);
        drive_set(s, 1'b1);
        checks++;
        if (out_addr !== BASE_ADDR || out_inst !== 32'h008000EF) begin
            errors++;
            $display("[TB] FAIL clear_base: addr=%08h inst=%08h, expected %08h 008000ef", out_addr, out_inst, BASE_ADDR);
        end
        wait_drain();
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_set(mk(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, 32'h00500093), 1'b1);
        end
        out_ready = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        expAddr = BASE_ADDR;
        checks++;
        if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b0 || out_inst !== 32'd0 ||
            out_addr !== 32'd0 || err_flag !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: count=%0d valid=%b ready=%b inst=%08h addr=%08h flag=%b, expected all 0",
                     count, out_valid, in_ready, out_inst, out_addr, err_flag);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b0;
        drive_set(mk(FMT_U, OP_LUI, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345000, 32'h123452B7), 1'b1);
        checks++;
        if (out_addr !== BASE_ADDR || out_inst !== 32'h123452B7) begin
            errors++;
            $display("[TB] FAIL post_reset_word: addr=%08h inst=%08h, expected %08h 123452b7", out_addr, out_inst, BASE_ADDR);
        end
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_encode();
        test_reject();
        test_back_to_back();
        test_clear();
        test_reset_midstream();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
